// File: rtl/piece_queue_ctrl.sv
// Piece preview queue and hold slot between the game FSM and the piece generator.
// Define PIECE_QUEUE_NO_REPEAT_EN to bump a captured index that repeats the newest queued piece.
module piece_queue_ctrl #(
    parameter int DEPTH = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 spawn_req,
    input  logic                 hold_req,
    output logic                 gen_new_block,
    input  logic [2:0]           gen_block_idx,
    output logic                 queue_ready,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_idx,
    output logic [3*DEPTH-1:0]   preview_idx,
    output logic                 hold_valid,
    output logic [2:0]           hold_idx
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          pending_q, pending_d;
    logic          activeValid_q, activeValid_d;
    logic          holdUsed_q, holdUsed_d;
    logic          queueReady_q, queueReady_d;
    logic          spawnValid_q, spawnValid_d;
    logic [2:0]    spawnIdx_q, spawnIdx_d;
    logic          holdValid_q, holdValid_d;
    logic [2:0]    holdIdx_q, holdIdx_d;
    logic [2:0]    slots_q [DEPTH];
    logic [2:0]    slots_d [DEPTH];

    logic [2:0]    sanIdx;
    logic [2:0]    capIdx;
    logic          doSpawn;
    logic          doHold;

    // Value that would be written into the queue if the generator is pulsed this cycle.
    always_comb begin
        sanIdx = (gen_block_idx > 3'd6) ? 3'd0 : gen_block_idx;
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        begin
            logic [2:0] prevIdx;
            logic       hasPrev;
            prevIdx = slots_q[DEPTH-1];
            hasPrev = 1'b1;
            if (state_q == FILL) begin
                hasPrev = (count_q != '0);
                prevIdx = slots_q[0];
                for (int i = 1; i < DEPTH; i++) begin
                    if (count_q == CW'(i)) begin
                        prevIdx = slots_q[i-1];
                    end
                end
            end
            if (hasPrev && (sanIdx == prevIdx)) begin
                capIdx = (sanIdx == 3'd6) ? 3'd0 : sanIdx + 3'd1;
            end else begin
                capIdx = sanIdx;
            end
        end
`else
        capIdx = sanIdx;
`endif
    end

    // Next-state logic: fill the queue, then serve spawns and hold swaps from it.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pending_d     = pending_q;
        activeValid_d = activeValid_q;
        holdUsed_d    = holdUsed_q;
        spawnValid_d  = 1'b0;
        spawnIdx_d    = spawnIdx_q;
        holdValid_d   = holdValid_q;
        holdIdx_d     = holdIdx_q;
        for (int i = 0; i < DEPTH; i++) begin
            slots_d[i] = slots_q[i];
        end
        gen_new_block = 1'b0;
        doSpawn       = 1'b0;
        doHold        = 1'b0;

        case (state_q)
            FILL: begin
                if (spawn_req) begin
                    pending_d = 1'b1;
                end
                if (count_q < CW'(DEPTH)) begin
                    gen_new_block = 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (count_q == CW'(i)) begin
                            slots_d[i] = capIdx;
                        end
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(DEPTH - 1)) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                doSpawn = spawn_req | pending_q;
                doHold  = hold_req & activeValid_q & ~holdUsed_q;
                // A first hold with an empty slot consumes a queue piece just like a spawn.
                if (doSpawn || (doHold && !holdValid_q)) begin
                    gen_new_block = 1'b1;
                    spawnIdx_d    = slots_q[0];
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        slots_d[i] = slots_q[i+1];
                    end
                    slots_d[DEPTH-1] = capIdx;
                    spawnValid_d  = 1'b1;
                    activeValid_d = 1'b1;
                    pending_d     = 1'b0;
                    holdUsed_d    = ~doSpawn;
                    if (!doSpawn) begin
                        holdIdx_d   = spawnIdx_q;
                        holdValid_d = 1'b1;
                    end
                end else if (doHold) begin
                    spawnIdx_d   = holdIdx_q;
                    holdIdx_d    = spawnIdx_q;
                    spawnValid_d = 1'b1;
                    holdUsed_d   = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        queueReady_d = (state_d == READY);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= FILL;
            count_q       <= '0;
            pending_q     <= 1'b0;
            activeValid_q <= 1'b0;
            holdUsed_q    <= 1'b0;
            queueReady_q  <= 1'b0;
            spawnValid_q  <= 1'b0;
            spawnIdx_q    <= 3'd0;
            holdValid_q   <= 1'b0;
            holdIdx_q     <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= 3'd0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            activeValid_q <= activeValid_d;
            holdUsed_q    <= holdUsed_d;
            queueReady_q  <= queueReady_d;
            spawnValid_q  <= spawnValid_d;
            spawnIdx_q    <= spawnIdx_d;
            holdValid_q   <= holdValid_d;
            holdIdx_q     <= holdIdx_d;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    always_comb begin
        preview_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            preview_idx[3*i +: 3] = slots_q[i];
        end
    end

    assign queue_ready = queueReady_q;
    assign spawn_valid = spawnValid_q;
    assign spawn_idx   = spawnIdx_q;
    assign hold_valid  = holdValid_q;
    assign hold_idx    = holdIdx_q;

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Self-checking bench for piece_queue_ctrl: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_piece_queue_ctrl;

    localparam int DEPTH = 3;

    logic               Clk;
    logic               Reset;
    logic               spawn_req;
    logic               hold_req;
    logic               gen_new_block;
    logic [2:0]         gen_block_idx;
    logic               queue_ready;
    logic               spawn_valid;
    logic [2:0]         spawn_idx;
    logic [3*DEPTH-1:0] preview_idx;
    logic               hold_valid;
    logic [2:0]         hold_idx;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;
    int lastGen;

    // Behavioural model state.
    int mq[$];
    bit mReady, mPend, mActive, mUsed, mHv, mSv;
    int mSidx, mHidx;

    piece_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .spawn_req     (spawn_req),
        .hold_req      (hold_req),
        .gen_new_block (gen_new_block),
        .gen_block_idx (gen_block_idx),
        .queue_ready   (queue_ready),
        .spawn_valid   (spawn_valid),
        .spawn_idx     (spawn_idx),
        .preview_idx   (preview_idx),
        .hold_valid    (hold_valid),
        .hold_idx      (hold_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int storeVal(int g, int prev, bit hasPrev);
        int s;
        s = (g > 6) ? 0 : g;
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        if (hasPrev && s == prev) s = (s + 1) % 7;
`endif
        return s;
    endfunction

    function automatic int expPreview();
        int r = 0;
        for (int i = 0; i < mq.size(); i++) r = r | (mq[i] << (3 * i));
        return r;
    endfunction

    function automatic int pk(int s0, int s1, int s2);
        return s0 | (s1 << 3) | (s2 << 6);
    endfunction

    function automatic bit expGen();
        if (!mReady) return mq.size() < DEPTH;
        return spawn_req || mPend || (hold_req && mActive && !mUsed && !mHv);
    endfunction

    // Pop the head as the new active piece and append a freshly generated one.
    task automatic modelQueueSpawn(int g);
        int w;
        w = storeVal(g, mq[mq.size()-1], 1'b1);
        mSidx = mq.pop_front();
        mq.push_back(w);
        mSv = 1;
        mActive = 1;
        mPend = 0;
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            mq.delete();
            {mReady, mPend, mActive, mUsed, mHv, mSv} = '0;
            mSidx = 0;
            mHidx = 0;
        end else begin
            mSv = 0;
            if (!mReady) begin
                if (spawn_req) mPend = 1;
                if (mq.size() < DEPTH) begin
                    if (mq.size() == 0) mq.push_back(storeVal(int'(gen_block_idx), 0, 1'b0));
                    else mq.push_back(storeVal(int'(gen_block_idx), mq[mq.size()-1], 1'b1));
                end
                if (mq.size() == DEPTH) mReady = 1;
            end else if (spawn_req || mPend) begin
                modelQueueSpawn(int'(gen_block_idx));
                mUsed = 0;
            end else if (hold_req && mActive && !mUsed) begin
                if (!mHv) begin
                    mHidx = mSidx;
                    mHv = 1;
                    modelQueueSpawn(int'(gen_block_idx));
                end else begin
                    int t;
                    t = mSidx;
                    mSidx = mHidx;
                    mHidx = t;
                    mSv = 1;
                end
                mUsed = 1;
            end
        end
    end

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (checkEn) begin
            checkOutput("queue_ready", int'(queue_ready), int'(mReady));
            checkOutput("spawn_valid", int'(spawn_valid), int'(mSv));
            checkOutput("spawn_idx", int'(spawn_idx), mSidx);
            checkOutput("preview_idx", int'(preview_idx), expPreview());
            checkOutput("hold_valid", int'(hold_valid), int'(mHv));
            checkOutput("hold_idx", int'(hold_idx), mHidx);
            if (!Reset) checkOutput("gen_new_block", int'(gen_new_block), int'(expGen()));
        end
    end

    task automatic applyStimulus(bit rst, bit sp, bit ho, int g);
        Reset = rst;
        spawn_req = sp;
        hold_req = ho;
        gen_block_idx = 3'(g);
        #2;
        lastGen = int'(gen_new_block);
        @(posedge Clk);
        #1;
        spawn_req = 1'b0;
        hold_req = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        spawn_req = 1'b0;
        hold_req = 1'b0;
        gen_block_idx = 3'd0;
        @(posedge Clk);
        #1;
        checkEn = 1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_ready", int'(queue_ready), 0);
        checkOutput("rst_preview", int'(preview_idx), 0);
        checkOutput("rst_hold_valid", int'(hold_valid), 0);

        // Fill with 2,5,1 then one spawn refilled by 4.
        applyStimulus(0, 0, 0, 2);
        checkOutput("fill1_gen", lastGen, 1);
        checkOutput("fill1_not_ready", int'(queue_ready), 0);
        applyStimulus(0, 0, 0, 5);
        applyStimulus(0, 0, 0, 1);
        checkOutput("fill3_gen", lastGen, 1);
        checkOutput("fill_ready", int'(queue_ready), 1);
        checkOutput("fill_preview", int'(preview_idx), pk(2, 5, 1));
        applyStimulus(0, 0, 0, 3);
        checkOutput("idle_gen", lastGen, 0);
        applyStimulus(0, 0, 1, 3);
        checkOutput("hold_no_active_gen", lastGen, 0);
        checkOutput("hold_no_active_hv", int'(hold_valid), 0);
        applyStimulus(0, 1, 0, 4);
        checkOutput("spawn_gen", lastGen, 1);
        checkOutput("spawn_valid", int'(spawn_valid), 1);
        checkOutput("spawn_idx", int'(spawn_idx), 2);
        checkOutput("spawn_preview", int'(preview_idx), pk(5, 1, 4));
        applyStimulus(0, 0, 0, 3);
        checkOutput("spawn_pulse_end", int'(spawn_valid), 0);

        // Hold into empty slot, repeated hold ignored, then swap after next spawn.
        applyStimulus(0, 0, 1, 6);
        checkOutput("hold1_gen", lastGen, 1);
        checkOutput("hold1_hidx", int'(hold_idx), 2);
        checkOutput("hold1_sidx", int'(spawn_idx), 5);
        checkOutput("hold1_preview", int'(preview_idx), pk(1, 4, 6));
        applyStimulus(0, 0, 1, 3);
        checkOutput("hold2_gen", lastGen, 0);
        checkOutput("hold2_pulse", int'(spawn_valid), 0);
        applyStimulus(0, 1, 0, 7);
        checkOutput("sanitise_preview", int'(preview_idx), pk(4, 6, 0));
        checkOutput("spawn2_idx", int'(spawn_idx), 1);
        applyStimulus(0, 0, 1, 2);
        checkOutput("swap_gen", lastGen, 0);
        checkOutput("swap_sidx", int'(spawn_idx), 2);
        checkOutput("swap_hidx", int'(hold_idx), 1);
        checkOutput("swap_pulse", int'(spawn_valid), 1);

        // Reset mid-READY with hold full, then pending spawn requested during fill.
        applyStimulus(1, 0, 0, 0);
        checkOutput("midrst_hv", int'(hold_valid), 0);
        checkOutput("midrst_sidx", int'(spawn_idx), 0);
        checkOutput("midrst_ready", int'(queue_ready), 0);
        applyStimulus(0, 1, 0, 3);
        checkOutput("pend_fill_gen", lastGen, 1);
        checkOutput("pend_no_spawn", int'(spawn_valid), 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 6);
        checkOutput("pend_ready", int'(queue_ready), 1);
        checkOutput("pend_still_none", int'(spawn_valid), 0);
        applyStimulus(0, 0, 0, 5);
        checkOutput("pend_gen", lastGen, 1);
        checkOutput("pend_spawn", int'(spawn_valid), 1);
        checkOutput("pend_sidx", int'(spawn_idx), 3);
        checkOutput("pend_preview", int'(preview_idx), pk(0, 6, 5));

        // Repeat handling on consecutive equal indices.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 3);
        applyStimulus(0, 0, 0, 3);
        applyStimulus(0, 0, 0, 6);
        applyStimulus(0, 1, 0, 6);
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        checkOutput("norep_preview", int'(preview_idx), pk(4, 6, 0));
`else
        checkOutput("rep_preview", int'(preview_idx), pk(3, 6, 6));
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 149) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0,
                          int'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piece_queue_ctrl.md
Name: piece_queue_ctrl

Overview:
- Sequencer between the game-control FSM and the pseudo-random piece generator.
- Pulses the generator's new_block request and captures the returned 3-bit piece index into a DEPTH-entry preview queue.
- Serves the game FSM's spawn requests from the queue head and refills the tail in the same cycle.
- Owns the hold slot: one swap allowed per spawned piece.

Parameters:
- DEPTH, 3, number of preview entries (legal range 2..6).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- spawn_req  input  1  game FSM requests the next falling piece; single-cycle pulse.
- hold_req  input  1  player hold/swap request; single-cycle pulse.
- gen_new_block  output  1  combinational request to the generator; generator index is valid in the same cycle.
- gen_block_idx  input  3  generator piece index, sampled only when gen_new_block=1.
- queue_ready  output  1  registered; queue full, state READY.
- spawn_valid  output  1  registered one-cycle pulse: a new active piece is presented.
- spawn_idx  output  3  registered index of the piece being spawned; held until the next spawn.
- preview_idx  output  3*DEPTH  registered queue contents; slot 0 (bits [2:0]) is the head.
- hold_valid  output  1  registered; hold slot occupied.
- hold_idx  output  3  registered hold slot contents.

Behaviour:
- Reset (synchronous, Clk rising edge):
  - state=FILL, count=0, pending=0, active_valid=0, hold_used=0.
  - All queue slots 0; every output register 0.
  - Reset mid-operation discards the queue, the hold slot and any pending request.
- State FILL:
  - gen_new_block=1 every cycle while count<DEPTH.
  - Captured index written to slot[count]; count increments.
  - When count reaches DEPTH, go to READY the next cycle.
  - Fill latency is exactly DEPTH cycles after reset deassertion.
- Index sanitising: a captured value >6 is written as 0.
- spawn_req seen in FILL sets pending=1. One level only: further requests while pending=1 are dropped.
- hold_req in FILL is ignored.
- State READY, spawn (spawn_req=1, or pending=1 on the first READY cycle):
  - spawn_idx<=slot0, spawn_valid<=1 the next cycle (latency 1).
  - slot[i]<=slot[i+1]; gen_new_block=1 the same cycle, and the captured index goes to slot[DEPTH-1].
  - Queue stays full, so there is no refill stall.
  - active_valid<=1, hold_used<=0, pending<=0.
- State READY, hold (hold_req=1, spawn_req=0, active_valid=1, hold_used=0):
  - If hold_valid=0: hold_idx<=spawn_idx, hold_valid<=1. Then perform a queue spawn exactly as above, except hold_used<=1.
  - If hold_valid=1: swap. spawn_idx<=hold_idx, hold_idx<=spawn_idx, spawn_valid<=1. The queue is untouched and gen_new_block stays 0. hold_used<=1.
- hold_req with hold_used=1 or active_valid=0 is ignored: no pulse, no state change.
- spawn_req and hold_req in the same cycle: spawn wins, hold is dropped.
- gen_new_block is never asserted in READY except on a queue spawn, so the generator sequence advances exactly once per consumed piece.
- queue_ready=1 iff state==READY. spawn_valid is 0 in every cycle other than the pulse.

Optional Feature:
- Macro PIECE_QUEUE_NO_REPEAT_EN.
- Defined: if a sanitised captured index equals the index in the immediately preceding queue slot (the newest entry before the write), store (idx+1) mod 7 instead. This applies to both fill and refill writes. Slot 0 during FILL has no predecessor and is never altered.
- Undefined: the captured index is stored unchanged after sanitising.

Test Plan:
- Reset, DEPTH=3, generator returns 2,5,1 -> gen_new_block high for 3 cycles; preview_idx={1,5,2}; queue_ready=1 on cycle 4.
- In READY, spawn_req with generator returning 4 -> next cycle spawn_valid=1, spawn_idx=2, preview_idx={4,1,5}, exactly one gen_new_block cycle.
- spawn_req during cycle 1 of FILL -> no spawn until READY; spawn_valid pulses the cycle after READY entry with spawn_idx equal to the first filled index.
- Active piece 2, hold empty: hold_req -> hold_idx=2, hold_valid=1, spawn_idx=old head. Second hold_req -> ignored. After spawn_req, hold_req -> swap returns 2 with no gen_new_block.
- Generator returns 7 -> stored 0. With PIECE_QUEUE_NO_REPEAT_EN, generator returns 3,3 -> stored 3,4; 6,6 -> stored 6,0.
- Reset asserted mid-READY with hold full -> all outputs 0 next cycle; refill restarts from FILL.
